// File: rtl/tx_frame_scheduler_if.sv
// tx_frame_scheduler_if: request, word-stream, config and tx-chain signals of the frame scheduler.
interface tx_frame_scheduler_if #(
  parameter int NUM_W = 8,
  parameter int TO_W  = 24,
  parameter int GAP_W = 16
);
  logic [1:0]       req;
  logic [NUM_W-1:0] req_num0;
  logic [NUM_W-1:0] req_num1;
  logic [1:0]       gnt;
  logic [31:0]      s0_data;
  logic             s0_valid;
  logic             s0_ready;
  logic [31:0]      s1_data;
  logic             s1_valid;
  logic             s1_ready;
  logic [GAP_W-1:0] cfg_gap;
  logic [TO_W-1:0]  cfg_timeout;
  logic [31:0]      tx_data;
  logic             tx_valid;
  logic [31:0]      tx_data_num;
  logic             tx_start;
  logic             tx_end_pulse;
  logic             tx_abort;
  logic             busy;
  logic             active_src;
  logic             done;
  logic             timeout_err;
  modport slave (
    input  req, req_num0, req_num1, s0_data, s0_valid, s1_data, s1_valid,
           cfg_gap, cfg_timeout, tx_end_pulse,
    output gnt, s0_ready, s1_ready, tx_data, tx_valid, tx_data_num, tx_start,
           tx_abort, busy, active_src, done, timeout_err
  );
  modport master (
    output req, req_num0, req_num1, s0_data, s0_valid, s1_data, s1_valid,
           cfg_gap, cfg_timeout, tx_end_pulse,
    input  gnt, s0_ready, s1_ready, tx_data, tx_valid, tx_data_num, tx_start,
           tx_abort, busy, active_src, done, timeout_err
  );
endinterface

// File: rtl/tx_frame_scheduler.sv
// tx_frame_scheduler: round-robin grant of two word streams into the tx FIFO, then start,
// wait for end-of-transmission with timeout, and hold an inter-frame gap.
module tx_frame_scheduler #(
  parameter int NUM_W = 8,
  parameter int TO_W  = 24,
  parameter int GAP_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  tx_frame_scheduler_if.slave   bus
);
  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_END, GAP, ZERO} state_t;
  state_t           state_q, state_d;
  logic             last_src_q, last_src_d;
  logic             active_src_q, active_src_d;
  logic [NUM_W-1:0] num_q, num_d;
  logic [NUM_W-1:0] cnt_q, cnt_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [GAP_W-1:0] gcnt_q, gcnt_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic [TO_W-1:0]  tcnt_q, tcnt_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [1:0]       ready_q, ready_d;
  logic [31:0]      tx_data_q, tx_data_d;
  logic [31:0]      tx_data_num_q, tx_data_num_d;
  logic             tx_valid_q, tx_valid_d;
  logic             tx_start_q, tx_start_d;
  logic             tx_abort_q, tx_abort_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             timeout_err_q, timeout_err_d;
  logic             win;
  logic [NUM_W-1:0] win_num;
  logic             hs;
  logic [31:0]      word;
  // On a tie the source that did not win last time is served.
  assign win     = (bus.req == 2'b11) ? ~last_src_q : bus.req[1];
  assign win_num = win ? bus.req_num1 : bus.req_num0;
  assign hs      = active_src_q ? (ready_q[1] & bus.s1_valid) : (ready_q[0] & bus.s0_valid);
  assign word    = active_src_q ? bus.s1_data : bus.s0_data;
  always_comb begin
    state_d       = state_q;
    last_src_d    = last_src_q;
    active_src_d  = active_src_q;
    num_d         = num_q;
    cnt_d         = cnt_q;
    gap_d         = gap_q;
    gcnt_d        = gcnt_q;
    to_d          = to_q;
    tcnt_d        = tcnt_q;
    ready_d       = ready_q;
    tx_data_d     = tx_data_q;
    tx_data_num_d = tx_data_num_q;
    gnt_d         = 2'b00;
    tx_valid_d    = 1'b0;
    tx_start_d    = 1'b0;
    tx_abort_d    = 1'b0;
    done_d        = 1'b0;
    timeout_err_d = 1'b0;
    unique case (state_q)
      IDLE: if (|bus.req) begin
        gnt_d         = win ? 2'b10 : 2'b01;
        active_src_d  = win;
        last_src_d    = win;
        num_d         = win_num;
        gap_d         = bus.cfg_gap;
        to_d          = bus.cfg_timeout;
        tx_data_num_d = {{(32-NUM_W){1'b0}}, win_num};
        cnt_d         = '0;
        ready_d       = (win_num == '0) ? 2'b00 : (win ? 2'b10 : 2'b01);
        state_d       = (win_num == '0) ? ZERO : LOAD;
      end
      // ready is dropped on the accept of the final word so no extra handshake slips in.
      LOAD: if (hs) begin
        tx_valid_d = 1'b1;
        tx_data_d  = word;
        cnt_d      = cnt_q + 1'b1;
        if (cnt_q == num_q - 1'b1) begin
          ready_d = 2'b00;
          state_d = START;
        end
      end
      START: begin
        tx_start_d = 1'b1;
        tcnt_d     = '0;
        state_d    = WAIT_END;
      end
      WAIT_END: if (bus.tx_end_pulse) begin
        done_d  = 1'b1;
        gcnt_d  = '0;
        state_d = GAP;
      end else if (to_q != '0 && tcnt_q == to_q - 1'b1) begin
        timeout_err_d = 1'b1;
        tx_abort_d    = 1'b1;
        gcnt_d        = '0;
        state_d       = GAP;
      end else begin
        tcnt_d = tcnt_q + TO_W'(~&tcnt_q);
      end
      GAP: if (gap_q == '0 || gcnt_q == gap_q - 1'b1) state_d = IDLE;
           else gcnt_d = gcnt_q + 1'b1;
      ZERO: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      last_src_q    <= 1'b1;
      active_src_q  <= 1'b0;
      num_q         <= '0;
      cnt_q         <= '0;
      gap_q         <= '0;
      gcnt_q        <= '0;
      to_q          <= '0;
      tcnt_q        <= '0;
      gnt_q         <= 2'b00;
      ready_q       <= 2'b00;
      tx_data_q     <= '0;
      tx_data_num_q <= '0;
      tx_valid_q    <= 1'b0;
      tx_start_q    <= 1'b0;
      tx_abort_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_src_q    <= last_src_d;
      active_src_q  <= active_src_d;
      num_q         <= num_d;
      cnt_q         <= cnt_d;
      gap_q         <= gap_d;
      gcnt_q        <= gcnt_d;
      to_q          <= to_d;
      tcnt_q        <= tcnt_d;
      gnt_q         <= gnt_d;
      ready_q       <= ready_d;
      tx_data_q     <= tx_data_d;
      tx_data_num_q <= tx_data_num_d;
      tx_valid_q    <= tx_valid_d;
      tx_start_q    <= tx_start_d;
      tx_abort_q    <= tx_abort_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      timeout_err_q <= timeout_err_d;
    end
  end
  assign bus.gnt         = gnt_q;
  assign bus.s0_ready    = ready_q[0];
  assign bus.s1_ready    = ready_q[1];
  assign bus.tx_data     = tx_data_q;
  assign bus.tx_valid    = tx_valid_q;
  assign bus.tx_data_num = tx_data_num_q;
  assign bus.tx_start    = tx_start_q;
  assign bus.tx_abort    = tx_abort_q;
  assign bus.busy        = busy_q;
  assign bus.active_src  = active_src_q;
  assign bus.done        = done_q;
  assign bus.timeout_err = timeout_err_q;
endmodule

// File: tb/tb_tx_frame_scheduler.sv
// tb_tx_frame_scheduler: directed bench; accepted source words go to a scoreboard and are
// popped against tx_data, frame events are timestamped and checked against expected cycles.
module tb_tx_frame_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  tx_frame_scheduler_if bus ();
  tx_frame_scheduler dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int n_cmp = 0, n_err = 0, cyc = 0;
  logic [31:0] sb[$];
  logic [1:0]  gq[$];
  int          gcq[$], dcq[$];
  int nv = 0, lv = 0, ns = 0, scyc = 0, nd = 0, dcyc = 0, nto = 0, tocyc = 0;
  int nab = 0, abcyc = 0, ng = 0, gcyc = 0, a1 = 0, r1late = 0, n0 = 0, n1 = 0;
  logic [1:0] glast = 2'b00;
  logic en0 = 1'b0, en1 = 1'b0, tog1 = 1'b0, hs0 = 1'b0, hs1 = 1'b0;
  int v0, s0, d0, t0, b0, pc, k0;
  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick(int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask
  task automatic wait_gnt(string tag, int lim);
    int k = ng;
    for (int i = 0; i < lim && ng == k; i++) tick();
    check(tag, ng, k + 1);
  endtask
  task automatic wait_start(string tag, int lim);
    int k = ns;
    for (int i = 0; i < lim && ns == k; i++) tick();
    check(tag, ns, k + 1);
  endtask
  task automatic pulse_end();
    bus.tx_end_pulse = 1'b1;
    pc = cyc;
    tick();
    bus.tx_end_pulse = 1'b0;
  endtask
  initial begin
    bus.req = 2'b00; bus.req_num0 = '0; bus.req_num1 = '0;
    bus.cfg_gap = '0; bus.cfg_timeout = '0; bus.tx_end_pulse = 1'b0;
    bus.s0_valid = 1'b0; bus.s0_data = '0; bus.s1_valid = 1'b0; bus.s1_data = '0;
    fork
      forever begin
        @(negedge clk);
        cyc++;
        if (!rst_n) begin
          sb.delete();
          hs0 = 1'b0;
          hs1 = 1'b0;
        end else begin
          if (hs0) begin sb.push_back(32'hA000_0000 | 32'(n0)); n0++; end
          if (hs1) begin sb.push_back(32'hB100_0000 | 32'(n1)); n1++; a1++; end
        end
        if (bus.tx_valid) begin
          nv++;
          lv = cyc;
          if (sb.size() == 0) check("tx_unexpected", 32'(bus.tx_valid), 0);
          else check("tx_data", bus.tx_data, sb.pop_front());
        end
        if (bus.tx_start) begin ns++; scyc = cyc; end
        if (bus.done) begin nd++; dcyc = cyc; dcq.push_back(cyc); end
        if (bus.timeout_err) begin nto++; tocyc = cyc; end
        if (bus.tx_abort) begin nab++; abcyc = cyc; end
        if (bus.gnt != 2'b00) begin
          ng++; gcyc = cyc; glast = bus.gnt;
          gq.push_back(bus.gnt); gcq.push_back(cyc);
        end
        if (a1 >= 3 && bus.s1_ready) r1late++;
        bus.s0_valid = en0;
        bus.s0_data  = 32'hA000_0000 | 32'(n0);
        bus.s1_valid = en1 && (!tog1 || cyc[0]);
        bus.s1_data  = 32'hB100_0000 | 32'(n1);
        hs0 = bus.s0_ready && bus.s0_valid;
        hs1 = bus.s1_ready && bus.s1_valid;
      end
    join_none
    tick(2);
    check("rst_flags", 32'({bus.gnt, bus.s0_ready, bus.s1_ready, bus.tx_valid, bus.tx_start,
          bus.tx_abort, bus.busy, bus.active_src, bus.done, bus.timeout_err}), 0);
    check("rst_tx_data", bus.tx_data, 0);
    check("rst_tx_num", bus.tx_data_num, 0);
    rst_n = 1'b1;
    tick(2);
    // single frame from source 0
    bus.cfg_gap = 2; bus.cfg_timeout = 0; en0 = 1'b1; bus.req_num0 = 4;
    v0 = nv; d0 = nd;
    bus.req = 2'b01;
    wait_gnt("t1_gnt_seen", 20);
    bus.req = 2'b00;
    check("t1_gnt", 32'(glast), 1);
    check("t1_num", bus.tx_data_num, 32'h0000_0004);
    check("t1_busy", 32'(bus.busy), 1);
    wait_start("t1_start_seen", 40);
    check("t1_words", nv - v0, 4);
    check("t1_start_lat", scyc, lv + 1);
    check("t1_src", 32'(bus.active_src), 0);
    tick(49);
    pulse_end();
    tick();
    check("t1_done_cnt", nd, d0 + 1);
    check("t1_done_lat", dcyc, pc + 1);
    tick(4);
    // source 1 with valid present every other cycle
    en0 = 1'b0; en1 = 1'b1; tog1 = 1'b1; bus.cfg_gap = 0; bus.req_num1 = 3;
    a1 = 0; r1late = 0; v0 = nv; d0 = nd;
    bus.req = 2'b10;
    wait_gnt("t3_gnt_seen", 20);
    bus.req = 2'b00;
    check("t3_gnt", 32'(glast), 2);
    wait_start("t3_start_seen", 60);
    check("t3_words", nv - v0, 3);
    check("t3_accepts", a1, 3);
    check("t3_start_lat", scyc, lv + 1);
    tick(3);
    check("t3_no_late_ready", r1late, 0);
    pulse_end();
    tick();
    check("t3_done_cnt", nd, d0 + 1);
    tick(3);
    // round robin with both requests held
    tog1 = 1'b0; en0 = 1'b1; en1 = 1'b1; bus.cfg_gap = 3;
    bus.req_num0 = 2; bus.req_num1 = 2;
    gq.delete(); gcq.delete(); dcq.delete();
    bus.req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_start("t2_start_seen", 60);
      tick(3);
      if (k == 3) bus.req = 2'b00;
      pulse_end();
    end
    tick(10);
    check("t2_grants", gq.size(), 4);
    check("t2_dones", dcq.size(), 4);
    if (gq.size() == 4 && dcq.size() == 4)
      for (int k = 0; k < 4; k++) begin
        check("t2_gnt_order", 32'(gq[k]), (k % 2 == 1) ? 2 : 1);
        if (k > 0) check("t2_gap", gcq[k] - dcq[k-1], 4);
      end
    // timeout, then a request queued during the gap
    bus.cfg_gap = 2; bus.cfg_timeout = 100; bus.req_num0 = 1; en1 = 1'b0;
    bus.req = 2'b01;
    wait_gnt("t4_gnt_seen", 20);
    bus.req = 2'b00;
    bus.cfg_timeout = 0;
    bus.cfg_gap = 7;
    wait_start("t4_start_seen", 40);
    k0 = scyc; t0 = nto; b0 = nab; d0 = nd;
    for (int i = 0; i < 150 && nto == t0; i++) tick();
    check("t4_to_cnt", nto, t0 + 1);
    check("t4_to_cycle", tocyc, k0 + 100);
    check("t4_abort_cnt", nab, b0 + 1);
    check("t4_abort_cycle", abcyc, tocyc);
    check("t4_no_done", nd, d0);
    bus.req_num1 = 1; en1 = 1'b1;
    bus.req = 2'b10;
    wait_gnt("t4_next_gnt_seen", 20);
    bus.req = 2'b00;
    check("t4_next_gnt", 32'(glast), 2);
    check("t4_next_gnt_cycle", gcyc, tocyc + 3);
    wait_start("t4_next_start_seen", 40);
    tick(150);
    check("t4_to_disabled", nto, t0 + 1);
    pulse_end();
    tick();
    check("t4_next_done", nd, d0 + 1);
    tick(12);
    d0 = nd;
    pulse_end();
    tick(2);
    check("stray_end_ignored", nd, d0);
    check("stray_end_idle", 32'(bus.busy), 0);
    // zero-length frame
    bus.cfg_gap = 0; bus.req_num0 = 0; v0 = nv; s0 = ns;
    bus.req = 2'b01;
    wait_gnt("t5_gnt_seen", 20);
    bus.req = 2'b00;
    tick(3);
    check("t5_done_cycle", dcyc, gcyc + 1);
    check("t5_no_words", nv, v0);
    check("t5_no_start", ns, s0);
    check("t5_idle", 32'(bus.busy), 0);
    // reset in the middle of loading
    bus.req_num0 = 5; k0 = n0;
    bus.req = 2'b01;
    wait_gnt("t6_gnt_seen", 20);
    bus.req = 2'b00;
    for (int i = 0; i < 20 && n0 - k0 < 2; i++) tick();
    check("t6_two_accepts", n0 - k0, 2);
    rst_n = 1'b0;
    #1;
    check("t6_rst_flags", 32'({bus.gnt, bus.s0_ready, bus.s1_ready, bus.tx_valid, bus.tx_start,
          bus.tx_abort, bus.busy, bus.active_src, bus.done, bus.timeout_err}), 0);
    check("t6_rst_tx_data", bus.tx_data, 0);
    check("t6_rst_tx_num", bus.tx_data_num, 0);
    tick(2);
    rst_n = 1'b1;
    tick();
    bus.req_num0 = 1; bus.req_num1 = 1; d0 = nd;
    bus.req = 2'b11;
    wait_gnt("t6_tie_gnt_seen", 20);
    bus.req = 2'b00;
    check("t6_tie_gnt", 32'(glast), 1);
    wait_start("t6_start_seen", 40);
    pulse_end();
    tick();
    check("t6_done", nd, d0 + 1);
    tick(3);
    check("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
